// File: rtl/chacha20_prng_seq.sv
// Sequential ChaCha20 block function: one column or diagonal half-round per clock,
// returning the first four output words as a 128-bit pseudo-random mask.
module chacha20_prng_seq #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] seed,
  input  logic [31:0]  round_number,
  output logic         busy,
  output logic         valid,
  output logic [127:0] random
);

  localparam int CNT_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      w   [16];
  logic [31:0]      nxt [16];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Returns {a, b, c, d} after one full quarter-round.
  function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Even counter values run the column half-round, odd values the diagonal one.
  always_comb begin
    nxt = w;
    if (!cnt[0]) begin
      {nxt[0], nxt[4], nxt[8],  nxt[12]} = qr(w[0], w[4], w[8],  w[12]);
      {nxt[1], nxt[5], nxt[9],  nxt[13]} = qr(w[1], w[5], w[9],  w[13]);
      {nxt[2], nxt[6], nxt[10], nxt[14]} = qr(w[2], w[6], w[10], w[14]);
      {nxt[3], nxt[7], nxt[11], nxt[15]} = qr(w[3], w[7], w[11], w[15]);
    end else begin
      {nxt[0], nxt[5], nxt[10], nxt[15]} = qr(w[0], w[5], w[10], w[15]);
      {nxt[1], nxt[6], nxt[11], nxt[12]} = qr(w[1], w[6], w[11], w[12]);
      {nxt[2], nxt[7], nxt[8],  nxt[13]} = qr(w[2], w[7], w[8],  w[13]);
      {nxt[3], nxt[4], nxt[9],  nxt[14]} = qr(w[3], w[4], w[9],  w[14]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      random <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w[0]  <= SIGMA0;
            w[1]  <= SIGMA1;
            w[2]  <= SIGMA2;
            w[3]  <= SIGMA3;
            for (int i = 0; i < 8; i++) w[4 + i] <= seed[32*i +: 32];
            w[12] <= round_number;
            w[13] <= '0;
            w[14] <= '0;
            w[15] <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            valid <= 1'b0;
            state <= ROUND;
          end
        end
        ROUND: begin
          w   <= nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FINAL;
        end
        FINAL: begin
          // The feed-forward of w0..w3 only needs the constants, which never change.
          random <= {w[3] + SIGMA3, w[2] + SIGMA2, w[1] + SIGMA1, w[0] + SIGMA0};
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_prng_seq.sv
// Bench for chacha20_prng_seq: vector table, corner-case sequences and random
// requests checked against a whole-block ChaCha20 reference function.
module tb_chacha20_prng_seq;

  localparam int ROUNDS  = 20;
  localparam int LATENCY = ROUNDS + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] seed;
  logic [31:0]  round_number;
  logic         busy;
  logic         valid;
  logic [127:0] random;

  int checks = 0;
  int errors = 0;

  chacha20_prng_seq #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed(seed),
    .round_number(round_number),
    .busy(busy),
    .valid(valid),
    .random(random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Quarter-round index sets: four columns then four diagonals.
  localparam int QI [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
  };

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] model(input logic [255:0] k, input logic [31:0] n);
    logic [31:0] s [16];
    logic [31:0] x [16];
    int a, b, c, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = n; s[13] = 0; s[14] = 0; s[15] = 0;
    x = s;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int q = 0; q < 4; q++) begin
        a = QI[(r % 2) * 4 + q][0]; b = QI[(r % 2) * 4 + q][1];
        c = QI[(r % 2) * 4 + q][2]; d = QI[(r % 2) * 4 + q][3];
        x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
      end
    end
    return {x[3] + s[3], x[2] + s[2], x[1] + s[1], x[0] + s[0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_seed();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle; returns the result and the edge
  // count from the accept edge to valid (-1 on timeout).
  task automatic run_req(input logic [255:0] s, input logic [31:0] n, input bit alter,
                         output logic [127:0] res, output int lat);
    seed = s; round_number = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (alter) begin
      seed = ~s; round_number = n + 32'd77;
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
    res = random;
  endtask

  typedef struct {
    logic [255:0] seed;
    logic [31:0]  rn;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [127:0] got [5];
  logic [255:0] sweep;
  logic [127:0] res;
  logic [127:0] exp_q [$];
  int           lat;

  initial begin
    for (int i = 0; i < 32; i++) sweep[8*i +: 8] = 8'(i);
    tbl[0] = '{seed: '0, rn: 32'd0, exp: 128'h28bd8653_e56a5d40_903df1a0_ade0b876};
    tbl[1] = '{seed: sweep, rn: 32'd1, exp: model(sweep, 32'd1)};
    tbl[2] = '{seed: sweep, rn: 32'd2, exp: model(sweep, 32'd2)};
    tbl[3] = '{seed: sweep, rn: 32'hFFFFFFFF, exp: model(sweep, 32'hFFFFFFFF)};
    tbl[4] = '{seed: ~sweep, rn: 32'h12345678, exp: model(~sweep, 32'h12345678)};

    rst_n = 1'b0; start = 1'b0; seed = '0; round_number = '0;
    #2;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_valid", 128'(valid), 128'd0);
    chk("reset_random", random, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_req(tbl[i].seed, tbl[i].rn, 1'b0, got[i], lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(LATENCY));
      chk($sformatf("vec%0d_random", i), got[i], tbl[i].exp);
      @(posedge clk); #1;
    end
    chk("sweep_1_vs_2_differ", 128'(got[1] == got[2]), 128'd0);
    chk("sweep_2_vs_max_differ", 128'(got[2] == got[3]), 128'd0);

    // Inputs altered right after the accept edge must not leak into the result.
    run_req(sweep, 32'd5, 1'b1, res, lat);
    chk("change_busy_latency", 128'(lat), 128'(LATENCY));
    chk("change_busy_random", res, model(sweep, 32'd5));
    @(posedge clk); #1;

    // A start pulse mid-computation is dropped, not queued.
    begin
      int   rises;
      logic pv;
      logic [127:0] first;
      seed = tbl[4].seed; round_number = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rises = 0; pv = 1'b0; first = '0;
      for (int c = 1; c <= 45; c++) begin
        start = (c == 10);
        @(posedge clk); #1;
        if (valid && !pv) begin
          rises++;
          first = random;
        end
        pv = valid;
      end
      start = 1'b0;
      chk("start_busy_one_valid", 128'(rises), 128'd1);
      chk("start_busy_random", first, model(tbl[4].seed, 32'd7));
      chk("start_busy_idle_after", 128'(busy), 128'd0);
    end

    // Start held high: results every ROUNDS+2 cycles with one idle cycle between.
    begin
      int   cyc, last_v, nres, nacc, lowrun;
      logic pb, pv;
      logic [31:0] rn;
      rn = 32'h100; seed = sweep; round_number = rn; start = 1'b1;
      cyc = 0; last_v = -1; nres = 0; nacc = 0; lowrun = 0; pb = busy; pv = valid;
      while (nres < 4 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
        if (busy && !pb) begin
          exp_q.push_back(model(sweep, rn));
          rn = rn + 1; round_number = rn;
          if (nacc > 0) chk("b2b_busy_gap", 128'(lowrun), 128'd1);
          nacc++;
          lowrun = 0;
        end else if (!busy) begin
          lowrun++;
        end
        if (valid && !pv) begin
          if (exp_q.size() > 0) chk($sformatf("b2b_random%0d", nres), random, exp_q.pop_front());
          else chk("b2b_unexpected_valid", 128'd1, 128'd0);
          if (last_v >= 0) chk("b2b_period", 128'(cyc - last_v), 128'(ROUNDS + 2));
          last_v = cyc;
          nres++;
        end
        pb = busy; pv = valid;
      end
      start = 1'b0;
      if (nres < 4) chk("b2b_timeout_results", 128'(nres), 128'd4);
      repeat (25) @(posedge clk);
      #1;
    end

    // Reset in the middle of ROUND clears everything at once.
    begin
      bit saw_valid, saw_busy;
      seed = sweep; round_number = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 128'(busy), 128'd0);
      chk("midreset_valid", 128'(valid), 128'd0);
      chk("midreset_random", random, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_valid = 0; saw_busy = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        if (valid) saw_valid = 1;
        if (busy) saw_busy = 1;
      end
      chk("postreset_no_valid", 128'(saw_valid), 128'd0);
      chk("postreset_idle", 128'(saw_busy), 128'd0);
    end

    for (int i = 0; i < 6; i++) begin
      logic [255:0] s;
      logic [31:0]  n;
      s = rand_seed();
      n = $urandom;
      run_req(s, n, 1'b0, res, lat);
      chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(LATENCY));
      chk($sformatf("rand%0d_random", i), res, model(s, n));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
